// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the datapath and pc_sequencer.
// The slave modport is the sequencer side; master is the datapath/driver side.
interface pc_sequencer_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned IMM_W   = 32,
  parameter int unsigned PHASE_W = 3
);
  logic               run;
  logic               stall;
  logic               halt_req;
  logic               branch;
  logic               zero;
  logic               jump;
  logic [IMM_W-1:0]   imm;
  logic [PHASE_W-1:0] state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus1;
  logic               busy;
  logic               retire;
  logic               halted;
  logic               fault;
  logic [31:0]        retire_count;

  modport master (
    output run, stall, halt_req, branch, zero, jump, imm,
    input  state, pc, pc_plus1, busy, retire, halted, fault, retire_count
  );

  modport slave (
    input  run, stall, halt_req, branch, zero, jump, imm,
    output state, pc, pc_plus1, busy, retire, halted, fault, retire_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Phase sequencer and PC unit: steps phases per instruction, resolves branch/jump on the
// last phase, and reports retirement, halt and out-of-range faults.
module pc_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned IMM_W      = 32,
  parameter int unsigned IMM_SHIFT  = 0,
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned PHASE_W    = 3,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned RESET_PC   = 0
) (
  input logic             i_clk,
  input logic             i_rst,
  pc_sequencer_if.slave   io_seq
);

  localparam int unsigned        ExtW      = (IMM_W > PC_W) ? IMM_W : PC_W;
  localparam logic [PHASE_W-1:0] LastPhase = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PC_W-1:0]    ResetPc   = PC_W'(RESET_PC);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} fsm_e;

  fsm_e               r_fsm, w_fsm_d;
  logic [PHASE_W-1:0] r_state, w_state_d;
  logic [PC_W-1:0]    r_pc, w_pc_d;
  logic               r_retire, w_retire_d;
  logic               r_fault, w_fault_d;
  logic               r_halt_pend, w_halt_pend_d;
  logic [31:0]        r_retire_count, w_retire_count_d;

  logic signed [ExtW-1:0] w_imm_ext;
  logic signed [ExtW-1:0] w_imm_sh;
  logic [PC_W-1:0]        w_pc_plus1;
  logic [PC_W-1:0]        w_target;
  logic [PC_W-1:0]        w_next;
  logic                   w_taken;
  logic                   w_oob;

  assign w_imm_ext  = ExtW'($signed(io_seq.imm));
  assign w_imm_sh   = w_imm_ext >>> IMM_SHIFT;
  assign w_pc_plus1 = r_pc + PC_W'(1);
  // Sum is formed at full width and truncated so the target wraps modulo 2**PC_W.
  assign w_target   = PC_W'(ExtW'(r_pc) + w_imm_sh);
  assign w_taken    = io_seq.jump | (io_seq.branch & io_seq.zero);
  assign w_next     = w_taken ? w_target : w_pc_plus1;
  assign w_oob      = 64'(w_next) >= 64'(IMEM_DEPTH);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm          <= StIdle;
      r_state        <= '0;
      r_pc           <= ResetPc;
      r_retire       <= 1'b0;
      r_fault        <= 1'b0;
      r_halt_pend    <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_fsm          <= w_fsm_d;
      r_state        <= w_state_d;
      r_pc           <= w_pc_d;
      r_retire       <= w_retire_d;
      r_fault        <= w_fault_d;
      r_halt_pend    <= w_halt_pend_d;
      r_retire_count <= w_retire_count_d;
    end
  end

  always_comb begin
    w_fsm_d          = r_fsm;
    w_state_d        = r_state;
    w_pc_d           = r_pc;
    w_retire_d       = 1'b0;
    w_fault_d        = r_fault;
    w_halt_pend_d    = r_halt_pend;
    w_retire_count_d = r_retire_count;

    unique case (r_fsm)
      StIdle: begin
        if (io_seq.run) begin
          w_fsm_d   = StRun;
          w_state_d = '0;
          w_pc_d    = ResetPc;
        end
      end

      StRun: begin
        // halt_req is remembered even across stalled edges.
        w_halt_pend_d = r_halt_pend | io_seq.halt_req;
        if (!io_seq.stall) begin
          if (r_state == LastPhase) begin
            w_state_d        = '0;
            w_retire_d       = 1'b1;
            w_retire_count_d = r_retire_count + 32'd1;
            if (w_oob) begin
              w_fault_d     = 1'b1;
              w_fsm_d       = StHalted;
              w_halt_pend_d = 1'b0;
            end else begin
              w_pc_d = w_next;
              if (r_halt_pend || io_seq.halt_req) begin
                w_fsm_d       = StHalted;
                w_halt_pend_d = 1'b0;
              end
            end
          end else begin
            w_state_d = r_state + PHASE_W'(1);
          end
        end
      end

      StHalted: ;

      default: w_fsm_d = StIdle;
    endcase
  end

  assign io_seq.state        = r_state;
  assign io_seq.pc           = r_pc;
  assign io_seq.pc_plus1     = w_pc_plus1;
  assign io_seq.busy         = (r_fsm == StRun);
  assign io_seq.retire       = r_retire;
  assign io_seq.halted       = (r_fsm == StHalted);
  assign io_seq.fault        = r_fault;
  assign io_seq.retire_count = r_retire_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: three instances differing only in IMEM_DEPTH
// (31, 1024, 512) share one stimulus set.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        run, stall, halt_req, branch, zero, jump;
  logic [31:0] imm;
  int          checks;
  int          failures;

  pc_sequencer_if #(.PC_W(10), .IMM_W(32), .PHASE_W(3)) if_a ();
  pc_sequencer_if #(.PC_W(10), .IMM_W(32), .PHASE_W(3)) if_b ();
  pc_sequencer_if #(.PC_W(10), .IMM_W(32), .PHASE_W(3)) if_c ();

  assign if_a.run = run;   assign if_a.stall = stall; assign if_a.halt_req = halt_req;
  assign if_a.branch = branch; assign if_a.zero = zero; assign if_a.jump = jump;
  assign if_a.imm = imm;
  assign if_b.run = run;   assign if_b.stall = stall; assign if_b.halt_req = halt_req;
  assign if_b.branch = branch; assign if_b.zero = zero; assign if_b.jump = jump;
  assign if_b.imm = imm;
  assign if_c.run = run;   assign if_c.stall = stall; assign if_c.halt_req = halt_req;
  assign if_c.branch = branch; assign if_c.zero = zero; assign if_c.jump = jump;
  assign if_c.imm = imm;

  pc_sequencer #(
    .PC_W(10), .IMM_W(32), .IMM_SHIFT(0), .NUM_PHASES(4), .PHASE_W(3),
    .IMEM_DEPTH(31), .RESET_PC(0)
  ) u_a (.i_clk(clk), .i_rst(rst), .io_seq(if_a));

  pc_sequencer #(
    .PC_W(10), .IMM_W(32), .IMM_SHIFT(0), .NUM_PHASES(4), .PHASE_W(3),
    .IMEM_DEPTH(1024), .RESET_PC(0)
  ) u_b (.i_clk(clk), .i_rst(rst), .io_seq(if_b));

  pc_sequencer #(
    .PC_W(10), .IMM_W(32), .IMM_SHIFT(0), .NUM_PHASES(4), .PHASE_W(3),
    .IMEM_DEPTH(512), .RESET_PC(0)
  ) u_c (.i_clk(clk), .i_rst(rst), .io_seq(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_ctl();
    run = 0; stall = 0; halt_req = 0; branch = 0; zero = 0; jump = 0; imm = '0;
  endtask

  // Reset, then one run edge: leaves every instance in RUN at phase 0, pc 0.
  task automatic start();
    clear_ctl();
    rst = 1; tick(1);
    rst = 0; run = 1; tick(1);
    run = 0;
  endtask

  task automatic test_reset();
    clear_ctl();
    rst = 1; tick(1);
    checks++;
    if (if_a.pc !== 10'd0) begin
      failures++; $display("FAIL reset_pc: got %0d want 0", if_a.pc);
    end
    checks++;
    if (if_a.state !== 3'd0) begin
      failures++; $display("FAIL reset_state: got %0d want 0", if_a.state);
    end
    checks++;
    if ({if_a.busy, if_a.retire, if_a.halted, if_a.fault} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got busy/retire/halted/fault=%b want 0000",
               {if_a.busy, if_a.retire, if_a.halted, if_a.fault});
    end
    checks++;
    if (if_a.retire_count !== 32'd0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", if_a.retire_count);
    end
    rst = 0;
  endtask

  task automatic test_sequential();
    start();
    for (int k = 0; k < 31; k++) begin
      for (int p = 1; p < 4; p++) begin
        tick(1);
        checks++;
        if (if_a.state !== 3'(p) || if_a.pc !== 10'(k)) begin
          failures++;
          $display("FAIL seq_phase: got state=%0d pc=%0d want state=%0d pc=%0d",
                   if_a.state, if_a.pc, p, k);
        end
      end
      checks++;
      if (if_a.pc_plus1 !== 10'(k + 1)) begin
        failures++; $display("FAIL seq_pc_plus1: got %0d want %0d", if_a.pc_plus1, k + 1);
      end
      tick(1);
      if (k < 30) begin
        checks++;
        if (if_a.pc !== 10'(k + 1) || if_a.state !== 3'd0 || if_a.retire !== 1'b1 ||
            if_a.retire_count !== 32'(k + 1)) begin
          failures++;
          $display("FAIL seq_retire: got pc=%0d state=%0d retire=%b count=%0d want %0d/0/1/%0d",
                   if_a.pc, if_a.state, if_a.retire, if_a.retire_count, k + 1, k + 1);
        end
      end else begin
        checks++;
        if (if_a.pc !== 10'd30 || if_a.fault !== 1'b1 || if_a.halted !== 1'b1 ||
            if_a.retire !== 1'b1 || if_a.retire_count !== 32'd31) begin
          failures++;
          $display("FAIL seq_fault: got pc=%0d fault=%b halted=%b retire=%b count=%0d want 30/1/1/1/31",
                   if_a.pc, if_a.fault, if_a.halted, if_a.retire, if_a.retire_count);
        end
      end
    end
    tick(2);
    checks++;
    if (if_a.pc !== 10'd30 || if_a.halted !== 1'b1 || if_a.retire !== 1'b0 ||
        if_a.busy !== 1'b0) begin
      failures++;
      $display("FAIL seq_halt_hold: got pc=%0d halted=%b retire=%b busy=%b want 30/1/0/0",
               if_a.pc, if_a.halted, if_a.retire, if_a.busy);
    end
  endtask

  task automatic test_branch();
    start();
    tick(20);
    checks++;
    if (if_b.pc !== 10'd5 || if_b.state !== 3'd0) begin
      failures++; $display("FAIL br_setup: got pc=%0d state=%0d want 5/0", if_b.pc, if_b.state);
    end
    tick(3);
    branch = 1; zero = 1; imm = 32'hFFFF_FFFD;
    tick(1);
    clear_ctl();
    checks++;
    if (if_b.pc !== 10'd2 || if_b.retire !== 1'b1 || if_b.state !== 3'd0 ||
        if_b.retire_count !== 32'd6) begin
      failures++;
      $display("FAIL br_taken: got pc=%0d retire=%b state=%0d count=%0d want 2/1/0/6",
               if_b.pc, if_b.retire, if_b.state, if_b.retire_count);
    end
    tick(12);
    tick(3);
    branch = 1; zero = 0; imm = 32'hFFFF_FFFD;
    tick(1);
    clear_ctl();
    checks++;
    if (if_b.pc !== 10'd6 || if_b.retire !== 1'b1) begin
      failures++;
      $display("FAIL br_not_taken: got pc=%0d retire=%b want 6/1", if_b.pc, if_b.retire);
    end
  endtask

  task automatic test_jump();
    start();
    tick(3);
    jump = 1; imm = 32'd100;
    tick(1);
    clear_ctl();
    checks++;
    if (if_b.pc !== 10'd100) begin
      failures++; $display("FAIL jmp_fwd: got pc=%0d want 100", if_b.pc);
    end
    tick(3);
    jump = 1; imm = 32'd1000;
    tick(1);
    clear_ctl();
    checks++;
    if (if_b.pc !== 10'd76 || if_b.fault !== 1'b0 || if_b.busy !== 1'b1) begin
      failures++;
      $display("FAIL jmp_wrap: got pc=%0d fault=%b busy=%b want 76/0/1",
               if_b.pc, if_b.fault, if_b.busy);
    end
    start();
    tick(3);
    jump = 1; imm = 32'd100;
    tick(1);
    clear_ctl();
    tick(3);
    jump = 1; imm = 32'd500;
    tick(1);
    clear_ctl();
    checks++;
    if (if_c.pc !== 10'd100 || if_c.fault !== 1'b1 || if_c.halted !== 1'b1 ||
        if_c.retire !== 1'b1 || if_c.retire_count !== 32'd2) begin
      failures++;
      $display("FAIL jmp_oob: got pc=%0d fault=%b halted=%b retire=%b count=%0d want 100/1/1/1/2",
               if_c.pc, if_c.fault, if_c.halted, if_c.retire, if_c.retire_count);
    end
    tick(1);
    checks++;
    if (if_c.retire !== 1'b0 || if_c.pc !== 10'd100 || if_c.fault !== 1'b1) begin
      failures++;
      $display("FAIL jmp_oob_hold: got retire=%b pc=%0d fault=%b want 0/100/1",
               if_c.retire, if_c.pc, if_c.fault);
    end
  endtask

  task automatic test_stall();
    start();
    tick(3);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (if_b.state !== 3'd3 || if_b.retire !== 1'b0 || if_b.pc !== 10'd0) begin
        failures++;
        $display("FAIL stall_hold: got state=%0d retire=%b pc=%0d want 3/0/0",
                 if_b.state, if_b.retire, if_b.pc);
      end
    end
    stall = 0;
    tick(1);
    checks++;
    if (if_b.state !== 3'd0 || if_b.pc !== 10'd1 || if_b.retire !== 1'b1 ||
        if_b.retire_count !== 32'd1) begin
      failures++;
      $display("FAIL stall_release: got state=%0d pc=%0d retire=%b count=%0d want 0/1/1/1",
               if_b.state, if_b.pc, if_b.retire, if_b.retire_count);
    end
    tick(1);
    checks++;
    if (if_b.retire !== 1'b0 || if_b.retire_count !== 32'd1) begin
      failures++;
      $display("FAIL stall_once: got retire=%b count=%0d want 0/1", if_b.retire,
               if_b.retire_count);
    end
  endtask

  task automatic test_halt();
    start();
    tick(28);
    tick(1);
    halt_req = 1;
    tick(1);
    halt_req = 0;
    tick(1);
    checks++;
    if (if_b.state !== 3'd3 || if_b.halted !== 1'b0 || if_b.busy !== 1'b1) begin
      failures++;
      $display("FAIL halt_pending: got state=%0d halted=%b busy=%b want 3/0/1",
               if_b.state, if_b.halted, if_b.busy);
    end
    tick(1);
    checks++;
    if (if_b.pc !== 10'd8 || if_b.state !== 3'd0 || if_b.halted !== 1'b1 ||
        if_b.retire !== 1'b1) begin
      failures++;
      $display("FAIL halt_done: got pc=%0d state=%0d halted=%b retire=%b want 8/0/1/1",
               if_b.pc, if_b.state, if_b.halted, if_b.retire);
    end
    run = 1;
    tick(3);
    run = 0;
    checks++;
    if (if_b.pc !== 10'd8 || if_b.halted !== 1'b1 || if_b.busy !== 1'b0 ||
        if_b.retire !== 1'b0) begin
      failures++;
      $display("FAIL halt_run_ignored: got pc=%0d halted=%b busy=%b retire=%b want 8/1/0/0",
               if_b.pc, if_b.halted, if_b.busy, if_b.retire);
    end
    start();
    tick(3);
    halt_req = 1;
    tick(1);
    halt_req = 0;
    checks++;
    if (if_b.halted !== 1'b1 || if_b.pc !== 10'd1) begin
      failures++;
      $display("FAIL halt_last_phase: got halted=%b pc=%0d want 1/1", if_b.halted, if_b.pc);
    end
  endtask

  task automatic test_reset_midrun();
    start();
    tick(48);
    tick(2);
    checks++;
    if (if_b.pc !== 10'd12 || if_b.state !== 3'd2 || if_b.retire_count !== 32'd12) begin
      failures++;
      $display("FAIL rst_setup: got pc=%0d state=%0d count=%0d want 12/2/12",
               if_b.pc, if_b.state, if_b.retire_count);
    end
    rst = 1;
    tick(1);
    rst = 0;
    checks++;
    if (if_b.pc !== 10'd0 || if_b.state !== 3'd0 || if_b.retire_count !== 32'd0 ||
        if_b.fault !== 1'b0 || if_b.busy !== 1'b0 || if_b.halted !== 1'b0) begin
      failures++;
      $display("FAIL rst_midrun: got pc=%0d state=%0d count=%0d fault=%b busy=%b halted=%b",
               if_b.pc, if_b.state, if_b.retire_count, if_b.fault, if_b.busy, if_b.halted);
    end
    tick(2);
    checks++;
    if (if_b.pc !== 10'd0 || if_b.state !== 3'd0 || if_b.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle_hold: got pc=%0d state=%0d busy=%b want 0/0/0",
               if_b.pc, if_b.state, if_b.busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1;
    clear_ctl();
    test_reset();
    test_sequential();
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_halt();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
